// File: rtl/interrupt_controller.sv
// Prioritised, non-nesting interrupt controller with a three-state fetch handshake (idle, request, service).
// Define IRQ_EDGE_DETECT_EN for rising-edge capture of i_irq; the default build captures level-sensitively.
module interrupt_controller #(
    parameter int unsigned N_SRC      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'd2,
    localparam int unsigned ID_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_SRC-1:0]  i_irq,
    input  logic              i_mask_we,
    input  logic [N_SRC-1:0]  i_mask_data,
    input  logic              i_stall,
    input  logic              i_ack,
    input  logic              i_rti,
    output logic              o_interrupt_call,
    output logic [31:0]       o_vector,
    output logic [ID_W-1:0]   o_irq_id,
    output logic [N_SRC-1:0]  o_pending,
    output logic [N_SRC-1:0]  o_mask,
    output logic              o_in_service
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQUEST = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0]       state;
    logic [N_SRC-1:0] set_vec;
    logic [N_SRC-1:0] clr_vec;
    logic [N_SRC-1:0] active;
    logic [ID_W-1:0]  sel_id;
    logic             any_active;
    logic             ack_take;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N_SRC-1:0] irq_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            irq_prev <= '0;
        end else begin
            irq_prev <= i_irq;
        end
    end

    always_comb begin
        set_vec = i_irq & ~irq_prev;
    end
`else
    always_comb begin
        set_vec = i_irq;
    end
`endif

    always_comb begin
        ack_take = (state == ST_REQUEST) && i_ack && !i_stall;
        clr_vec  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            clr_vec[i] = ack_take && (o_irq_id == ID_W'(i));
        end
    end

    // Arbitration uses the registered pending/mask, which yields the two-edge request latency
    // and delays the effect of a mask write by one cycle.
    always_comb begin
        active     = o_pending & ~o_mask;
        any_active = |active;
        sel_id     = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (active[i-1]) begin
                sel_id = ID_W'(i - 1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= ST_IDLE;
            o_pending        <= '0;
            o_mask           <= '0;
            o_irq_id         <= '0;
            o_vector         <= VEC_BASE;
            o_interrupt_call <= 1'b0;
            o_in_service     <= 1'b0;
        end else begin
            // Set is applied after clear so a same-cycle set keeps the bit.
            o_pending <= (o_pending & ~clr_vec) | set_vec;
            if (i_mask_we) begin
                o_mask <= i_mask_data;
            end
            case (state)
                ST_IDLE: begin
                    if (any_active) begin
                        state            <= ST_REQUEST;
                        o_irq_id         <= sel_id;
                        o_vector         <= VEC_BASE + 32'(sel_id) * VEC_STRIDE;
                        o_interrupt_call <= 1'b1;
                    end
                end
                ST_REQUEST: begin
                    if (ack_take) begin
                        state            <= ST_SERVICE;
                        o_interrupt_call <= 1'b0;
                        o_in_service     <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (i_rti) begin
                        state        <= ST_IDLE;
                        o_in_service <= 1'b0;
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    o_interrupt_call <= 1'b0;
                    o_in_service     <= 1'b0;
                end
            endcase
        end
    end

endmodule
